// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline results first, queued load returns in idle slots.
// Optional SWT16_WBARB_PENDING_MASK_EN builds the per-register pending-load mask.
module wb_port_arbiter #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int LD_FIFO_DEPTH   = 2,
    parameter int MAX_WAIT        = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_act_write_res_to_reg,
    input  logic [IALU_WORD_WIDTH-1:0]   in_res,
    input  logic [REG_IDX_WIDTH-1:0]     in_res_reg_idx,
    input  logic                         ld_valid,
    input  logic [IALU_WORD_WIDTH-1:0]   ld_data,
    input  logic [REG_IDX_WIDTH-1:0]     ld_reg_idx,
    output logic                         ld_ready,
    output logic                         out_pipe_stall,
    output logic                         out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0]   out_res,
    output logic [REG_IDX_WIDTH-1:0]     out_res_reg_idx,
    output logic [2**REG_IDX_WIDTH-1:0]  out_pending_mask
);
    localparam int PW = $clog2(LD_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LP_DEPTH    = CW'(LD_FIFO_DEPTH);
    localparam logic [WW-1:0] LP_MAX_WAIT = WW'(MAX_WAIT);

    logic [IALU_WORD_WIDTH-1:0] r_mem_data [LD_FIFO_DEPTH];
    logic [REG_IDX_WIDTH-1:0]   r_mem_idx  [LD_FIFO_DEPTH];
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic [WW-1:0]              r_wait;
    logic                       r_pipe_stall;
    logic                       r_act;
    logic [IALU_WORD_WIDTH-1:0] r_res;
    logic [REG_IDX_WIDTH-1:0]   r_idx;

    logic          w_empty;
    logic          w_full;
    logic          w_enq;
    logic          w_grant_head;
    logic          w_grant_pipe;
    logic [WW-1:0] w_wait_nxt;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == LP_DEPTH);
    assign w_enq        = ld_valid && !w_full;
    // A forced stall hands the slot to the head regardless of the pipeline.
    assign w_grant_head = !w_empty && (r_pipe_stall || !in_act_write_res_to_reg);
    assign w_grant_pipe = !r_pipe_stall && in_act_write_res_to_reg;

    always_comb begin
        w_wait_nxt = '0;
        if (!w_empty && !w_grant_head) begin
            w_wait_nxt = (r_wait == LP_MAX_WAIT) ? r_wait : r_wait + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_mem_data[r_wr_ptr] <= ld_data;
            r_mem_idx[r_wr_ptr]  <= ld_reg_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_wait       <= '0;
            r_pipe_stall <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant_head) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count      <= r_count + CW'(w_enq) - CW'(w_grant_head);
            r_wait       <= w_wait_nxt;
            r_pipe_stall <= (w_wait_nxt == LP_MAX_WAIT);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_act <= 1'b0;
            r_res <= '0;
            r_idx <= '0;
        end else if (w_grant_head) begin
            r_act <= 1'b1;
            r_res <= r_mem_data[r_rd_ptr];
            r_idx <= r_mem_idx[r_rd_ptr];
        end else if (w_grant_pipe) begin
            r_act <= 1'b1;
            r_res <= in_res;
            r_idx <= in_res_reg_idx;
        end else begin
            r_act <= 1'b0;
        end
    end

    assign ld_ready                 = !w_full;
    assign out_pipe_stall           = r_pipe_stall;
    assign out_act_write_res_to_reg = r_act;
    assign out_res                  = r_res;
    assign out_res_reg_idx          = r_idx;

`ifdef SWT16_WBARB_PENDING_MASK_EN
    logic [2**REG_IDX_WIDTH-1:0] w_mask;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
            if ({1'b0, PW'(i) - r_rd_ptr} < r_count) begin
                w_mask[r_mem_idx[i]] = 1'b1;
            end
        end
    end

    assign out_pending_mask = w_mask;
`else
    assign out_pending_mask = '0;
`endif

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback result and out-of-band load-return data from the data-memory interface. Pipeline results win by default. Load returns queue in a small FIFO and drain in idle slots. A wait counter forces a one-cycle pipeline stall so that queued loads cannot starve. The block sits between the writeback stage and the register file and drives the register-file write port.

## Interface
- IALU_WORD_WIDTH, 16, result/data word width
- REG_IDX_WIDTH, 4, register index width
- LD_FIFO_DEPTH, 2, load-return FIFO entries; power of two, ≥2
- MAX_WAIT, 4, cycles a non-empty FIFO head may be denied before a forced stall; ≥1

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_act_write_res_to_reg  in  1  pipeline writeback request
- in_res  in  IALU_WORD_WIDTH  pipeline result
- in_res_reg_idx  in  REG_IDX_WIDTH  pipeline destination register
- ld_valid  in  1  load return valid
- ld_data  in  IALU_WORD_WIDTH  load data
- ld_reg_idx  in  REG_IDX_WIDTH  load destination register
- ld_ready  out  1  FIFO can accept
- out_pipe_stall  out  1  pipeline must hold its writeback request this cycle
- out_act_write_res_to_reg  out  1  register-file write enable
- out_res  out  IALU_WORD_WIDTH  register-file write data
- out_res_reg_idx  out  REG_IDX_WIDTH  register-file write index
- out_pending_mask  out  2**REG_IDX_WIDTH  registers with queued load writes (see Configuration)

## Operation
- Load FIFO: entry = {ld_data, ld_reg_idx}. Enqueue on ld_valid && ld_ready. ld_ready = !full, derived from registered count only. When the FIFO is full, no enqueue happens that cycle, even if a dequeue occurs in the same cycle. Pointers wrap modulo LD_FIFO_DEPTH.
- Grant per cycle, mutually exclusive:
  - out_pipe_stall=1: FIFO head granted. in_act_write_res_to_reg is ignored; upstream holds it.
  - else if in_act_write_res_to_reg=1: pipeline granted.
  - else if FIFO non-empty: head granted and dequeued.
  - else: no write.
- Wait counter: +1 each cycle the FIFO is non-empty and the head is not granted. It saturates at MAX_WAIT. It clears to 0 on a head grant or when the FIFO is empty.
- out_pipe_stall is a register, set in the next cycle when the counter equals MAX_WAIT. It is asserted for exactly one cycle per forced grant, then the counter is 0.
- Write port outputs are registered copies of the granted source. When nothing is granted, out_act_write_res_to_reg=0 and data/index hold their last values.
- No ordering check between the pipeline and queued loads to the same register; the hazard unit owns that, using out_pending_mask.
- Reset mid-operation flushes the FIFO: queued loads are discarded, pointers, count and counter go to 0, out_pipe_stall goes to 0.

## Timing
- Reset values: ld_ready=1, out_pipe_stall=0, out_act_write_res_to_reg=0, out_res=0, out_res_reg_idx=0, out_pending_mask=0.
- Pipeline request at cycle N → write port active in cycle N+1 (latency 1).
- Load accepted at N, head eligible at N+1, written at N+2 at the earliest.
- Maximum head wait: MAX_WAIT denied cycles, then out_pipe_stall in the next cycle, then write one cycle later.
- ld_ready and out_pipe_stall have no combinational path from any input.

## Configuration
- SWT16_WBARB_PENDING_MASK_EN defined: out_pending_mask bit r = OR over valid FIFO entries with reg_idx==r. It is combinational from FIFO state and updates the cycle after enqueue or dequeue.
- Not defined: out_pending_mask tied to 0 and no mask logic is built.

## Test plan
- Reset: assert reset for 2 cycles with ld_valid=1 → all outputs at reset values, nothing enqueued.
- Pipeline only: in_act=1, in_res=16'h1234, idx=3 at cycle N → out_act=1, out_res=16'h1234, out_res_reg_idx=3 at N+1. Next cycle, with in_act=0 → out_act=0.
- Idle drain: one load of 16'hBEEF to r5 with pipeline idle → write of 16'hBEEF to r5 two cycles after acceptance. With the macro defined, mask=16'h0020 for one cycle before that write.
- Full FIFO: three back-to-back loads with continuous pipeline writes (DEPTH=2) → ld_ready=0 after the second acceptance; the third load is held until a dequeue.
- Starvation: one load queued, pipeline writes continuously (MAX_WAIT=4) → out_pipe_stall=1 for exactly one cycle after 4 denials, load written the following cycle, counter restarts.
- Reset mid-queue: two loads queued, reset pulsed for 1 cycle → FIFO empty, mask=0, no load write appears afterwards.
